// File: rtl/calc_ctrl.sv
// calc_ctrl: command sequencer for a small ALU sitting next to an external
// register bank with combinational read data. A command is accepted in IDLE.
// The sequencer then reads operand A and operand B through the bank port,
// executes the operation, writes the result back, and presents a response
// that is held until the consumer takes it.
// Optional feature: define CALC_MUL_EN to enable opcode 111 (MUL). When it is
// not defined, MUL is rejected as an illegal opcode and no multiplier is built.
module calc_ctrl #(
  parameter int NREGS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_src_a,
  input  logic [3:0] cmd_src_b,
  input  logic [3:0] cmd_dst,
  input  logic [7:0] cmd_imm,
  output logic       rb_we,
  output logic [3:0] rb_address,
  output logic [7:0] rb_wdata,
  input  logic [7:0] rb_rdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_carry,
  output logic       rsp_zero,
  output logic       rsp_err
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    EXEC,
    WR,
    RESP
  } state_t;

  state_t     state;

  // Command fields captured at acceptance.
  logic [2:0] op_q;
  logic [3:0] src_b_q;
  logic [3:0] dst_q;
  logic [7:0] imm_q;

  // Operands read from the bank and the result of the execute step.
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [7:0] res_q;
  logic       carry_q;
  logic       zero_q;

  logic       uses_a;
  logic       uses_b;
  logic       op_legal;
  logic       cmd_err;

  logic [7:0] alu_res;
  logic       alu_carry;
  logic       alu_zero;

`ifdef CALC_MUL_EN
  logic [15:0] mul_prod;
  assign mul_prod = {8'd0, a_q} * {8'd0, b_q};
`endif

  function automatic logic addr_bad(input logic [3:0] addr);
    return int'(addr) >= NREGS;
  endfunction

  // Decode which addresses the incoming opcode uses and whether it is rejected.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (which would infer a latch).
    uses_a   = 1'b1;
    uses_b   = 1'b1;
    op_legal = 1'b1;
    case (cmd_op)
      OP_MOV: uses_b = 1'b0;
      OP_LDI: begin
        uses_a = 1'b0;
        uses_b = 1'b0;
      end
`ifndef CALC_MUL_EN
      OP_MUL: op_legal = 1'b0;
`endif
      default: ;
    endcase
    cmd_err = !op_legal
            || (uses_a && addr_bad(cmd_src_a))
            || (uses_b && addr_bad(cmd_src_b))
            || addr_bad(cmd_dst);
  end

  // ALU on the latched operands; the result is captured only in EXEC.
  always_comb begin
    alu_res   = 8'd0;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD: {alu_carry, alu_res} = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB: begin
        alu_res   = a_q - b_q;
        alu_carry = (a_q < b_q);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_MOV: alu_res = a_q;
      OP_LDI: alu_res = imm_q;
`ifdef CALC_MUL_EN
      OP_MUL: begin
        alu_res   = mul_prod[7:0];
        alu_carry = (mul_prod[15:8] != 8'd0);
      end
`endif
      default: ;
    endcase
    alu_zero = (alu_res == 8'd0);
  end

  // Main sequencer: state and all registered outputs, loaded for the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      rb_we      <= 1'b0;
      rb_address <= 4'd0;
      rb_wdata   <= 8'd0;
      rsp_valid  <= 1'b0;
      rsp_result <= 8'd0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      op_q       <= OP_ADD;
      src_b_q    <= 4'd0;
      dst_q      <= 4'd0;
      imm_q      <= 8'd0;
      a_q        <= 8'd0;
      b_q        <= 8'd0;
      res_q      <= 8'd0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every read in this block sees the pre-edge value.
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            src_b_q   <= cmd_src_b;
            dst_q     <= cmd_dst;
            imm_q     <= cmd_imm;
            cmd_ready <= 1'b0;
            if (cmd_err) begin
              state      <= RESP;
              rsp_valid  <= 1'b1;
              rsp_err    <= 1'b1;
              rsp_result <= 8'd0;
              rsp_carry  <= 1'b0;
              rsp_zero   <= 1'b0;
            end else if (cmd_op == OP_LDI) begin
              state <= EXEC;
            end else begin
              state      <= RD_A;
              rb_address <= cmd_src_a;
            end
          end
        end
        RD_A: begin
          a_q <= rb_rdata;
          if (op_q == OP_MOV) begin
            state      <= EXEC;
            rb_address <= 4'd0;
          end else begin
            state      <= RD_B;
            rb_address <= src_b_q;
          end
        end
        RD_B: begin
          b_q        <= rb_rdata;
          state      <= EXEC;
          rb_address <= 4'd0;
        end
        EXEC: begin
          res_q      <= alu_res;
          carry_q    <= alu_carry;
          zero_q     <= alu_zero;
          state      <= WR;
          rb_we      <= 1'b1;
          rb_address <= dst_q;
          rb_wdata   <= alu_res;
        end
        WR: begin
          state      <= RESP;
          rb_we      <= 1'b0;
          rb_address <= 4'd0;
          rb_wdata   <= 8'd0;
          rsp_valid  <= 1'b1;
          rsp_result <= res_q;
          rsp_carry  <= carry_q;
          rsp_zero   <= zero_q;
          rsp_err    <= 1'b0;
        end
        RESP: begin
          if (rsp_ready) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_result <= 8'd0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed testbench for calc_ctrl. Models the attached register bank
// (combinational read, write on rising edge when rb_we) and checks every
// command against hand-computed results. Honours CALC_MUL_EN the same way
// as the design.
module tb_calc_ctrl;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_src_a;
  logic [3:0] cmd_src_b;
  logic [3:0] cmd_dst;
  logic [7:0] cmd_imm;
  logic       rb_we;
  logic [3:0] rb_address;
  logic [7:0] rb_wdata;
  logic [7:0] rb_rdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_zero;
  logic       rsp_err;

  int tests_run    = 0;
  int tests_failed = 0;

  // Bank model plus write observation.
  logic [7:0] bank [16];
  int         wr_count = 0;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  int         idle_wdata_viol = 0;

  calc_ctrl #(.NREGS(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_src_a  (cmd_src_a),
    .cmd_src_b  (cmd_src_b),
    .cmd_dst    (cmd_dst),
    .cmd_imm    (cmd_imm),
    .rb_we      (rb_we),
    .rb_address (rb_address),
    .rb_wdata   (rb_wdata),
    .rb_rdata   (rb_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rb_rdata = bank[rb_address];

  always @(posedge clk) begin
    if (rb_we === 1'b1) begin
      bank[rb_address] <= rb_wdata;
      wr_count         <= wr_count + 1;
      wr_addr          <= rb_address;
      wr_data          <= rb_wdata;
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b0 && rb_we === 1'b0 && rb_wdata !== 8'd0)
      idle_wdata_viol <= idle_wdata_viol + 1;
  end

  // Present one command at a falling edge; it is accepted at the next rising edge.
  // Afterwards the cmd_* inputs are scrambled so that a design that fails to latch them misbehaves.
  task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] d, input logic [7:0] imm);
    int n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL issue_ready: cmd_ready=%b expected 1", cmd_ready);
    end
    cmd_op    = op;
    cmd_src_a = a;
    cmd_src_b = b;
    cmd_dst   = d;
    cmd_imm   = imm;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_src_a = 4'hF;
    cmd_src_b = 4'hF;
    cmd_dst   = 4'hE;
    cmd_imm   = ~imm;
  endtask

  // Called right after issue: the cycle following the acceptance edge is cycle 1.
  task automatic wait_rsp(output int cyc);
    cyc = 1;
    while (rsp_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Complete the response handshake and confirm the return to IDLE.
  task automatic ack(input string name);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    tests_run++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_ack: rsp_valid=%b cmd_ready=%b expected 0/1", name, rsp_valid, cmd_ready);
    end
  endtask

  // One complete command with inline checks of latency, response fields and bank writes.
  task automatic do_op(input string name, input logic [2:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] d, input logic [7:0] imm,
                       input logic [7:0] exp_res, input logic exp_c, input logic exp_z,
                       input logic exp_err, input int exp_lat);
    int cyc;
    int base;
    int exp_wr;
    base   = wr_count;
    exp_wr = exp_err ? 0 : 1;
    issue(op, a, b, d, imm);
    wait_rsp(cyc);
    tests_run++;
    if (rsp_valid !== 1'b1 || cyc != exp_lat) begin
      tests_failed++;
      $display("FAIL %s_latency: rsp_valid=%b in cycle %0d expected 1 in cycle %0d",
               name, rsp_valid, cyc, exp_lat);
    end
    tests_run++;
    if (rsp_result !== exp_res || rsp_carry !== exp_c || rsp_zero !== exp_z || rsp_err !== exp_err) begin
      tests_failed++;
      $display("FAIL %s_rsp: result=%0d carry=%b zero=%b err=%b expected %0d/%b/%b/%b",
               name, rsp_result, rsp_carry, rsp_zero, rsp_err, exp_res, exp_c, exp_z, exp_err);
    end
    tests_run++;
    if (wr_count - base != exp_wr) begin
      tests_failed++;
      $display("FAIL %s_writes: %0d bank writes expected %0d", name, wr_count - base, exp_wr);
    end else if (exp_wr == 1) begin
      tests_run++;
      if (wr_addr !== d || wr_data !== exp_res) begin
        tests_failed++;
        $display("FAIL %s_wr: addr=%0d data=%0d expected %0d/%0d", name, wr_addr, wr_data, d, exp_res);
      end
    end
    ack(name);
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (cmd_ready !== 1'b1 || rb_we !== 1'b0 || rb_address !== 4'd0 || rb_wdata !== 8'd0 ||
        rsp_valid !== 1'b0 || rsp_result !== 8'd0 || rsp_carry !== 1'b0 ||
        rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: ready=%b we=%b addr=%0d wdata=%0d rv=%b res=%0d c=%b z=%b e=%b expected 1/0/0/0/0/0/0/0/0",
               cmd_ready, rb_we, rb_address, rb_wdata, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add();
    bank[1] <= 8'd200;
    bank[2] <= 8'd100;
    do_op("add", 3'b000, 4'd1, 4'd2, 4'd3, 8'd0, 8'd44, 1'b1, 1'b0, 1'b0, 5);
  endtask

  task automatic test_sub();
    bank[4] <= 8'd5;
    bank[5] <= 8'd5;
    do_op("sub_zero",   3'b001, 4'd4, 4'd5, 4'd6, 8'd0, 8'd0,   1'b0, 1'b1, 1'b0, 5);
    do_op("sub_borrow", 3'b001, 4'd4, 4'd2, 4'd7, 8'd0, 8'd161, 1'b1, 1'b0, 1'b0, 5);
  endtask

  task automatic test_logic();
    do_op("and", 3'b010, 4'd1, 4'd2, 4'd0, 8'd0, 8'h40, 1'b0, 1'b0, 1'b0, 5);
    do_op("or",  3'b011, 4'd1, 4'd2, 4'd0, 8'd0, 8'hEC, 1'b0, 1'b0, 1'b0, 5);
    do_op("xor", 3'b100, 4'd1, 4'd2, 4'd0, 8'd0, 8'hAC, 1'b0, 1'b0, 1'b0, 5);
  endtask

  // MOV ignores src_b, so an out-of-range src_b must not raise an error.
  task automatic test_mov();
    do_op("mov", 3'b101, 4'd1, 4'd15, 4'd0, 8'd0, 8'd200, 1'b0, 1'b0, 1'b0, 4);
  endtask

  // LDI ignores both sources; dst 9 is the highest legal address.
  task automatic test_ldi();
    do_op("ldi", 3'b110, 4'd15, 4'd15, 4'd9, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0, 3);
    tests_run++;
    if (bank[9] !== 8'hA5) begin
      tests_failed++;
      $display("FAIL ldi_bank: bank[9]=%0h expected a5", bank[9]);
    end
  endtask

  task automatic test_addr_err();
    do_op("err_dst",  3'b000, 4'd1,  4'd2,  4'd10, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1);
    do_op("err_srcb", 3'b001, 4'd1,  4'd12, 4'd3,  8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1);
    do_op("err_srca", 3'b101, 4'd10, 4'd0,  4'd3,  8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1);
  endtask

  task automatic test_backpressure();
    int cyc;
    issue(3'b000, 4'd1, 4'd2, 4'd3, 8'd0);
    wait_rsp(cyc);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_result !== 8'd44 || rsp_carry !== 1'b1 ||
          rsp_zero !== 1'b0 || rsp_err !== 1'b0 || cmd_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_%0d: rv=%b res=%0d c=%b z=%b e=%b ready=%b expected 1/44/1/0/0/0",
                 i, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err, cmd_ready);
      end
    end
    ack("hold");
  endtask

  // rsp_ready held high from before acceptance must not shorten the sequence.
  task automatic test_early_ready();
    int cyc;
    int base;
    base = wr_count;
    rsp_ready = 1'b1;
    issue(3'b000, 4'd4, 4'd5, 4'd8, 8'd0);
    wait_rsp(cyc);
    tests_run++;
    if (cyc != 5 || rsp_result !== 8'd10 || wr_count - base != 1) begin
      tests_failed++;
      $display("FAIL early_ready: cycle=%0d result=%0d writes=%0d expected 5/10/1",
               cyc, rsp_result, wr_count - base);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    tests_run++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL early_ready_idle: rsp_valid=%b cmd_ready=%b expected 0/1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    base = wr_count;
    issue(3'b000, 4'd1, 4'd2, 4'd3, 8'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    tests_run++;
    if (rb_we !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rb_address !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: we=%b rv=%b ready=%b addr=%0d expected 0/0/1/0",
               rb_we, rsp_valid, cmd_ready, rb_address);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    tests_run++;
    if (wr_count != base || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_after: writes=%0d rv=%b ready=%b expected 0/0/1",
               wr_count - base, rsp_valid, cmd_ready);
    end
    do_op("post_reset_ldi", 3'b110, 4'd0, 4'd0, 4'd2, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0, 3);
  endtask

  task automatic test_mul();
    bank[7] <= 8'd16;
    bank[8] <= 8'd17;
`ifdef CALC_MUL_EN
    do_op("mul", 3'b111, 4'd7, 4'd8, 4'd0, 8'd0, 8'h10, 1'b1, 1'b0, 1'b0, 5);
`else
    do_op("mul_illegal", 3'b111, 4'd7, 4'd8, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1);
`endif
  endtask

  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_src_a = 4'd0;
    cmd_src_b = 4'd0;
    cmd_dst   = 4'd0;
    cmd_imm   = 8'd0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) bank[i] = 8'd0;

    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_mov();
    test_ldi();
    test_addr_err();
    test_backpressure();
    test_early_ready();
    test_reset_mid();
    test_mul();

    tests_run++;
    if (idle_wdata_viol != 0) begin
      tests_failed++;
      $display("FAIL wdata_outside_wr: %0d cycles with nonzero rb_wdata while rb_we=0, expected 0",
               idle_wdata_viol);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
